spi_master: RTL

//  Soft SPI master that drives the synth's SPI slave port (sim model of the MCU side, reusable for bring-up).

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_write_queue.sv | 62 ++++++
 rtl/spi_master.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: frame layout, sizes and FSM states.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS   = 32;
  localparam int unsigned SPI_SAMPLE_BITS  = 16;
  localparam int unsigned SPI_NUMBER_BITS  = 15;
  localparam int unsigned SPI_VALUE_BITS   = 16;
  localparam int unsigned SPI_BIT_CNT_BITS = 5;

  typedef struct packed {
    logic                       write;
    logic [SPI_NUMBER_BITS-1:0] number;
    logic [SPI_VALUE_BITS-1:0]  value;
  } spi_frame_t;

  typedef enum logic {
    IDLE,
    RUN
  } spi_master_state_t;

  // A register-write frame when a write is pending, otherwise an all-zero idle frame.
  function automatic spi_frame_t spi_make_frame(input logic                       wr,
                                                input logic [SPI_NUMBER_BITS-1:0] num,
                                                input logic [SPI_VALUE_BITS-1:0]  val);
    spi_frame_t f;
    f = '0;
    if (wr) begin
      f.write  = 1'b1;
      f.number = num;
      f.value  = val;
    end
    return f;
  endfunction

endpackage

// File: rtl/spi_write_queue.sv
// Small FIFO of pending register writes; head is read combinationally, ready/empty are registered.
module spi_write_queue
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic                       i_Push,
  input  logic                       i_Pop,
  input  logic [SPI_NUMBER_BITS-1:0] i_Number,
  input  logic [SPI_VALUE_BITS-1:0]  i_Value,
  output logic                       o_Ready,
  output logic                       o_Empty,
  output logic [SPI_NUMBER_BITS-1:0] o_Head_number_c,
  output logic [SPI_VALUE_BITS-1:0]  o_Head_value_c
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W  = SPI_NUMBER_BITS + SPI_VALUE_BITS;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next_c;
  logic               do_push_c;
  logic               do_pop_c;

  // Push while full is legal only when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop_c     = i_Pop && (count != '0);
    do_push_c    = i_Push && ((count != CNT_W'(DEPTH)) || do_pop_c);
    count_next_c = count;
    if (do_push_c && !do_pop_c) count_next_c = count + CNT_W'(1);
    if (!do_push_c && do_pop_c) count_next_c = count - CNT_W'(1);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_Ready <= 1'b1;
      o_Empty <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count   <= count_next_c;
      o_Ready <= (count_next_c != CNT_W'(DEPTH));
      o_Empty <= (count_next_c == '0);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push_c) mem[wr_ptr] <= {i_Number, i_Value};
  end

  assign {o_Head_number_c, o_Head_value_c} = mem[rd_ptr];

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: streams 32-bit register-write / idle frames on MOSI, collects 16-bit MISO samples.
// Build option: SPI_MASTER_WRITE_QUEUE_EN turns the single write holding register into a 4-entry FIFO.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_SCK = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic                       i_Enable,
  input  logic                       i_WriteValid,
  output logic                       o_WriteReady,
  input  logic [SPI_NUMBER_BITS-1:0] i_WriteNumber,
  input  logic [SPI_VALUE_BITS-1:0]  i_WriteValue,
  output logic                       o_Busy,
  output logic                       o_SampleValid,
  output logic [SPI_SAMPLE_BITS-1:0] o_Sample,
  output logic                       o_SPI_SCK,
  output logic                       o_SPI_MOSI,
  input  logic                       i_SPI_MISO
);

  localparam int unsigned HALF_CNT_BITS = (CLKS_PER_HALF_SCK > 1) ? $clog2(CLKS_PER_HALF_SCK) : 1;
  localparam logic [HALF_CNT_BITS-1:0] HALF_TC = HALF_CNT_BITS'(CLKS_PER_HALF_SCK - 1);

  spi_master_state_t state;
  spi_master_state_t state_next;

  logic [HALF_CNT_BITS-1:0]    half_cnt;
  logic [SPI_BIT_CNT_BITS-1:0] bit_cnt;
  logic [SPI_FRAME_BITS-2:0]   frame_sh;
  logic [SPI_SAMPLE_BITS-2:0]  rx_sh;
  logic                        ready_q;

  logic                        load_c;
  logic                        rise_c;
  logic                        fall_c;
  logic                        push_c;
  logic                        pop_c;
  logic                        pend_valid_c;
  logic [SPI_NUMBER_BITS-1:0]  pend_number_c;
  logic [SPI_VALUE_BITS-1:0]   pend_value_c;
  spi_frame_t                  frame_c;

  assign o_WriteReady = ready_q;
  assign push_c       = i_WriteValid && ready_q;
  assign pop_c        = load_c && pend_valid_c;
  assign frame_c      = spi_make_frame(pend_valid_c, pend_number_c, pend_value_c);

`ifdef SPI_MASTER_WRITE_QUEUE_EN
  logic q_empty;

  spi_write_queue #(.DEPTH(4)) u_write_queue (
    .i_Clock         (i_Clock),
    .i_Reset_n       (i_Reset_n),
    .i_Push          (push_c),
    .i_Pop           (pop_c),
    .i_Number        (i_WriteNumber),
    .i_Value         (i_WriteValue),
    .o_Ready         (ready_q),
    .o_Empty         (q_empty),
    .o_Head_number_c (pend_number_c),
    .o_Head_value_c  (pend_value_c)
  );

  assign pend_valid_c = !q_empty;
`else
  logic hold_full;
  logic hold_full_next_c;

  // Ready means empty, so a push and a pop can never coincide here.
  assign hold_full_next_c = push_c || (hold_full && !pop_c);
  assign pend_valid_c     = hold_full;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      hold_full     <= 1'b0;
      pend_number_c <= '0;
      pend_value_c  <= '0;
      ready_q       <= 1'b1;
    end else begin
      if (push_c) begin
        pend_number_c <= i_WriteNumber;
        pend_value_c  <= i_WriteValue;
      end
      hold_full <= hold_full_next_c;
      ready_q   <= !hold_full_next_c;
    end
  end
`endif

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Frame boundary is the falling edge after the bit counter wraps; stop or reload there.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    rise_c     = 1'b0;
    fall_c     = 1'b0;
    case (state)
      IDLE: begin
        if (i_Enable) begin
          load_c     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (half_cnt == HALF_TC) begin
          if (!o_SPI_SCK) begin
            rise_c = 1'b1;
          end else begin
            fall_c = 1'b1;
            if (bit_cnt == '0) begin
              if (i_Enable) load_c = 1'b1;
              else          state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      half_cnt      <= '0;
      bit_cnt       <= '0;
      frame_sh      <= '0;
      rx_sh         <= '0;
      o_SPI_SCK     <= 1'b0;
      o_SPI_MOSI    <= 1'b0;
      o_Busy        <= 1'b0;
      o_Sample      <= '0;
      o_SampleValid <= 1'b0;
    end else begin
      o_SampleValid <= 1'b0;
      o_Busy        <= (state_next == RUN);
      if (state == RUN && half_cnt != HALF_TC) half_cnt <= half_cnt + HALF_CNT_BITS'(1);
      else                                     half_cnt <= '0;

      if (rise_c) begin
        o_SPI_SCK <= 1'b1;
        rx_sh     <= {rx_sh[SPI_SAMPLE_BITS-3:0], i_SPI_MISO};
        bit_cnt   <= bit_cnt + SPI_BIT_CNT_BITS'(1);
        if (bit_cnt[3:0] == 4'hF) begin
          o_Sample      <= {rx_sh, i_SPI_MISO};
          o_SampleValid <= 1'b1;
        end
      end
      if (fall_c) o_SPI_SCK <= 1'b0;

      if (load_c) begin
        o_SPI_MOSI <= frame_c[SPI_FRAME_BITS-1];
        frame_sh   <= frame_c[SPI_FRAME_BITS-2:0];
      end else if (fall_c) begin
        if (bit_cnt == '0) begin
          o_SPI_MOSI <= 1'b0;
        end else begin
          o_SPI_MOSI <= frame_sh[SPI_FRAME_BITS-2];
          frame_sh   <= {frame_sh[SPI_FRAME_BITS-3:0], 1'b0};
        end
      end
    end
  end

endmodule
